// File: rtl/float_add_reg.sv
// Registered Float adder for the linear-domain accumulator path.
// Flush-to-zero, no NaN, selectable rounding, one result per cycle.
module float_add_reg #(
  parameter int EXP  = 5,
  parameter int FRAC = 10
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic [EXP+FRAC:0]   a,
  input  logic [EXP+FRAC:0]   b,
  input  logic [2:0]          rnd,
  output logic                out_valid,
  output logic [EXP+FRAC:0]   z,
  output logic [7:0]          status
);

  localparam int W   = 1 + EXP + FRAC;
  localparam int MW  = FRAC + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = ((EXP > LZW) ? EXP : LZW) + 2;
  localparam int EMX = (1 << EXP) - 1;

  localparam logic [EXP-1:0] EONES = {EXP{1'b1}};
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RUP = 3'd2;
  localparam logic [2:0] RDN = 3'd3;
  localparam logic [2:0] RNA = 3'd4;

  function automatic logic [EW-1:0] lzc(input logic [MW-1:0] v);
    lzc = EW'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc = EW'(MW - 1 - i);
  endfunction

  logic          r_valid;
  logic [W-1:0]  r_z;
  logic [7:0]    r_status;

  logic [W-1:0]    w_z;
  logic [7:0]      w_st;
  logic [2:0]      w_mode;
  logic            w_za, w_zb, w_ia, w_ib;
  logic [W-2:0]    w_maga, w_magb;
  logic            w_swap;
  logic            w_sl, w_ss;
  logic [EXP-1:0]  w_el, w_es, w_diff;
  logic [FRAC:0]   w_ml, w_ms;
  logic [MW-1:0]   w_lx, w_sx, w_al;
  logic [MW:0]     w_sum;
  logic [MW-1:0]   w_nm;
  logic [EW-1:0]   w_lz, w_en, w_er;
  logic            w_g, w_rs, w_inx, w_inc;
  logic [FRAC+1:0] w_mr;
  logic [FRAC-1:0] w_fr;
  logic            w_toinf;

  // Full combinational add: swap, align, add, normalize, round, pack.
  always_comb begin
    w_z     = '0;
    w_st    = '0;
    w_mode  = (rnd > RNA) ? RNE : rnd;
    w_za    = a[W-2:FRAC] == '0;
    w_zb    = b[W-2:FRAC] == '0;
    w_ia    = a[W-2:FRAC] == EONES;
    w_ib    = b[W-2:FRAC] == EONES;
    w_maga  = w_za ? '0 : a[W-2:0];
    w_magb  = w_zb ? '0 : b[W-2:0];
    w_swap  = w_magb > w_maga;
    w_sl    = w_swap ? b[W-1] : a[W-1];
    w_ss    = w_swap ? a[W-1] : b[W-1];
    w_el    = w_swap ? w_magb[W-2:FRAC] : w_maga[W-2:FRAC];
    w_es    = w_swap ? w_maga[W-2:FRAC] : w_magb[W-2:FRAC];
    w_ml    = (w_el == '0) ? '0
            : {1'b1, (w_swap ? w_magb[FRAC-1:0] : w_maga[FRAC-1:0])};
    w_ms    = (w_es == '0) ? '0
            : {1'b1, (w_swap ? w_maga[FRAC-1:0] : w_magb[FRAC-1:0])};
    w_diff  = w_el - w_es;
    w_lx    = {w_ml, 3'b000};
    w_sx    = {w_ms, 3'b000};
    if (32'(w_diff) >= MW) begin
      w_al = {{(MW-1){1'b0}}, |w_sx};
    end else begin
      w_al    = w_sx >> w_diff;
      w_al[0] = w_al[0] | (|(w_sx & ~({MW{1'b1}} << w_diff)));
    end
    w_sum   = (w_sl ^ w_ss) ? ({1'b0, w_lx} - {1'b0, w_al})
                            : ({1'b0, w_lx} + {1'b0, w_al});
    w_lz    = lzc(w_sum[MW-1:0]);
    if (w_sum[MW]) begin
      w_nm = w_sum[MW:1] | {{(MW-1){1'b0}}, w_sum[0]};
      w_en = {{(EW-EXP){1'b0}}, w_el} + EW'(1);
    end else begin
      w_nm = w_sum[MW-1:0] << w_lz;
      w_en = {{(EW-EXP){1'b0}}, w_el} - w_lz;
    end
    w_g     = w_nm[2];
    w_rs    = |w_nm[1:0];
    w_inx   = w_g | w_rs;
    w_inc   = 1'b0;
    case (w_mode)
      RNE:     w_inc = w_g & (w_rs | w_nm[3]);
      RTZ:     w_inc = 1'b0;
      RUP:     w_inc = w_inx & ~w_sl;
      RDN:     w_inc = w_inx & w_sl;
      RNA:     w_inc = w_g;
      default: w_inc = w_g & (w_rs | w_nm[3]);
    endcase
    w_mr    = {1'b0, w_nm[MW-1:3]} + {{(FRAC+1){1'b0}}, w_inc};
    w_er    = w_mr[FRAC+1] ? (w_en + EW'(1)) : w_en;
    w_fr    = w_mr[FRAC+1] ? w_mr[FRAC:1] : w_mr[FRAC-1:0];
    w_toinf = (w_mode == RNE) || (w_mode == RNA)
           || ((w_mode == RUP) && !w_sl)
           || ((w_mode == RDN) && w_sl);
    if (w_ia || w_ib) begin
      if (w_ia && w_ib && (a[W-1] != b[W-1])) begin
        w_z     = {1'b0, EONES, {FRAC{1'b0}}};
        w_st[2] = 1'b1;
      end else begin
        w_z = {(w_ia ? a[W-1] : b[W-1]), EONES, {FRAC{1'b0}}};
      end
      w_st[1] = 1'b1;
    end else if (w_sum == '0) begin
      w_z     = {((w_sl == w_ss) ? w_sl : (w_mode == RDN)),
                 {(W-1){1'b0}}};
      w_st[0] = 1'b1;
    end else if (w_er[EW-1] || (w_er == '0)) begin
      w_z     = {w_sl, {(W-1){1'b0}}};
      w_st[0] = 1'b1;
      w_st[3] = 1'b1;
      w_st[5] = 1'b1;
    end else if (w_er >= EW'(EMX)) begin
      w_st[4] = 1'b1;
      w_st[5] = 1'b1;
      if (w_toinf) begin
        w_z     = {w_sl, EONES, {FRAC{1'b0}}};
        w_st[1] = 1'b1;
      end else begin
        w_z = {w_sl, EONES - EXP'(1), {FRAC{1'b1}}};
      end
    end else begin
      w_z     = {w_sl, w_er[EXP-1:0], w_fr};
      w_st[5] = w_inx;
    end
  end

  // Output register; result and flags hold while no new operand arrives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_z      <= '0;
      r_status <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_z      <= w_z;
        r_status <= w_st;
      end
    end
  end

  assign out_valid = r_valid;
  assign z         = r_z;
  assign status    = r_status;

endmodule

// File: tb/tb_float_add_reg.sv
// Directed-vector bench for float_add_reg at EXP=5, FRAC=10.
// Table of hand-computed sums plus streaming and async reset sequences.
module tb_float_add_reg;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rnd;
    logic [15:0] z;
    logic [7:0]  st;
  } vec_t;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  rnd;
  logic        out_valid;
  logic [15:0] z;
  logic [7:0]  status;

  int total;
  int bad;

  vec_t vt[$];

  float_add_reg #(.EXP(5), .FRAC(10)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .rnd       (rnd),
    .out_valid (out_valid),
    .z         (z),
    .status    (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [2:0] tr);
    @(negedge clock);
    a        = ta;
    b        = tb;
    rnd      = tr;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [15:0] ta, input logic [15:0] tb,
                     input logic [2:0] tr, input logic [15:0] tz,
                     input logic [7:0] ts);
    vec_t v;
    v.a = ta; v.b = tb; v.rnd = tr; v.z = tz; v.st = ts;
    vt.push_back(v);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    rnd      = '0;

    add(16'h3C00, 16'h3C00, 3'd0, 16'h4000, 8'h00);
    add(16'h3C00, 16'hBC00, 3'd0, 16'h0000, 8'h01);
    add(16'h3C00, 16'hBC00, 3'd3, 16'h8000, 8'h01);
    add(16'h3C00, 16'h1000, 3'd0, 16'h3C00, 8'h20);
    add(16'h3C00, 16'h1000, 3'd2, 16'h3C01, 8'h20);
    add(16'h3C00, 16'h1000, 3'd4, 16'h3C01, 8'h20);
    add(16'h3C00, 16'h1000, 3'd1, 16'h3C00, 8'h20);
    add(16'h3C00, 16'h1000, 3'd3, 16'h3C00, 8'h20);
    add(16'hBC00, 16'h9000, 3'd2, 16'hBC00, 8'h20);
    add(16'hBC00, 16'h9000, 3'd3, 16'hBC01, 8'h20);
    add(16'h3C01, 16'h1000, 3'd0, 16'h3C02, 8'h20);
    add(16'h3C01, 16'h1000, 3'd5, 16'h3C02, 8'h20);
    add(16'h3C00, 16'h0C00, 3'd0, 16'h3C00, 8'h20);
    add(16'h3C00, 16'h0C00, 3'd2, 16'h3C01, 8'h20);
    add(16'h3C00, 16'h0400, 3'd2, 16'h3C01, 8'h20);
    add(16'h3FFF, 16'h1000, 3'd2, 16'h4000, 8'h20);
    add(16'h3C00, 16'h3800, 3'd0, 16'h3E00, 8'h00);
    add(16'h3C00, 16'hB800, 3'd0, 16'h3800, 8'h00);
    add(16'hBC00, 16'h4000, 3'd0, 16'h3C00, 8'h00);
    add(16'h7BFF, 16'h7BFF, 3'd0, 16'h7C00, 8'h32);
    add(16'h7BFF, 16'h7BFF, 3'd1, 16'h7BFF, 8'h30);
    add(16'hFBFF, 16'hFBFF, 3'd2, 16'hFBFF, 8'h30);
    add(16'hFBFF, 16'hFBFF, 3'd3, 16'hFC00, 8'h32);
    add(16'hFBFF, 16'hFBFF, 3'd4, 16'hFC00, 8'h32);
    add(16'h0600, 16'h8400, 3'd0, 16'h0000, 8'h29);
    add(16'h8600, 16'h0400, 3'd0, 16'h8000, 8'h29);
    add(16'h3C00, 16'h0001, 3'd0, 16'h3C00, 8'h00);
    add(16'h7C00, 16'hFC00, 3'd0, 16'h7C00, 8'h06);
    add(16'hFC00, 16'h3C00, 3'd0, 16'hFC00, 8'h02);
    add(16'h7C00, 16'h7C00, 3'd0, 16'h7C00, 8'h02);
    add(16'h8000, 16'h8000, 3'd0, 16'h8000, 8'h01);
    add(16'h8000, 16'h0000, 3'd0, 16'h0000, 8'h01);
    add(16'h8000, 16'h0000, 3'd3, 16'h8000, 8'h01);

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].a, vt[i].b, vt[i].rnd);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_z", i), 32'(z), 32'(vt[i].z));
      chk($sformatf("v%0d_st", i), 32'(status), 32'(vt[i].st));
    end

    drive(16'h3C00, 16'h3C00, 3'd0);
    chk("s0_z", 32'(z), 32'h4000);
    drive(16'h3C00, 16'h3800, 3'd0);
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_z", 32'(z), 32'h3E00);
    drive(16'h4000, 16'h4000, 3'd0);
    chk("s2_valid", 32'(out_valid), 32'd1);
    chk("s2_z", 32'(z), 32'h4400);

    @(negedge clock);
    in_valid = 1'b0;
    a        = 16'h7BFF;
    b        = 16'h7BFF;
    @(posedge clock);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_z", 32'(z), 32'h4400);
    chk("idle_st", 32'(status), 32'h00);

    drive(16'h7BFF, 16'h7BFF, 3'd0);
    chk("pre_rst_z", 32'(z), 32'h7C00);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_z", 32'(z), 32'd0);
    chk("async_st", 32'(status), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    drive(16'h3C00, 16'hBC00, 3'd3);
    chk("post_rst_z", 32'(z), 32'h8000);
    chk("post_rst_st", 32'(status), 32'h01);

    @(negedge clock);
    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_add_reg.md
Name: float_add_reg

Overview:
- Registered floating-point adder, z = a + b, operating on the codebase's biased Float format (sign | exponent | fraction).
- Non-IEEE-compliant mode: denormals flush to zero, no NaN.
- Selectable rounding.
- Sits in the linear-domain accumulator path: it sums a running Float accumulator with a converted log-domain term, one result per cycle.

Parameters:
- EXP, 5: exponent field width in bits; bias = 2^(EXP-1)-1.
- FRAC, 10: stored fraction width in bits (hidden leading 1 implied).

Ports:
- clock, input, 1: rising-edge clock.
- resetn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: a, b and rnd are valid this cycle.
- a, input, 1+EXP+FRAC: operand A, {sign, exp, frac}.
- b, input, 1+EXP+FRAC: operand B, same format.
- rnd, input, 3: rounding mode.
- out_valid, output, 1: z and status hold a result.
- z, output, 1+EXP+FRAC: rounded sum.
- status, output, 8: flags. bit0 zero, bit1 infinity, bit2 invalid, bit3 tiny, bit4 huge, bit5 inexact, bits7:6 = 0.

Behaviour:
- Encoding:
  - exp==0 means zero; any frac is ignored (denormal input reads as zero of that sign).
  - exp==all-ones means infinity; frac is ignored.
  - Otherwise the value is (-1)^s * 1.frac * 2^(exp-bias).
- Rounding modes (rnd):
  - 000: nearest, ties to even.
  - 001: toward zero.
  - 010: toward +inf.
  - 011: toward -inf.
  - 100: nearest, ties away from zero.
  - 101-111: treated as 000.
- Datapath:
  - Swap operands so |A| >= |B|.
  - Align B right by the exponent difference, keeping guard, round and sticky bits; a shift >= FRAC+3 collapses B into sticky.
  - Add or subtract significands.
  - Normalize with a leading-zero count, left shift after cancellation or a 1-bit right shift on carry-out.
  - Round per rnd.
  - Renormalize on a rounding carry.
- Zero results:
  - Exact zero from opposite-sign operands is +0 in every mode except 011, which gives -0.
  - Zero + zero keeps the sign if both signs agree.
- Overflow (exponent >= all-ones after rounding):
  - Set huge and inexact.
  - Modes 000 and 100 return signed infinity.
  - Mode 001, and directed modes rounding toward zero, return the signed max finite value {exp=all-ones-1, frac=all-ones}.
- Underflow: a normalized result exponent <= 0 sets tiny and inexact, and returns signed zero (no denormal output).
- Infinity handling:
  - inf + finite returns that inf.
  - inf + inf of the same sign returns that inf.
  - +inf + -inf returns +inf with invalid set.
  - status.infinity is set whenever z is an infinity.
- status.zero is set whenever z is a zero. status.inexact is set whenever rounding discarded nonzero bits.
- Timing:
  - One-cycle latency: operands sampled on the rising edge when in_valid=1.
  - z, status and out_valid update on that edge.
  - When in_valid=0, out_valid goes to 0 next cycle and z/status hold their previous values.
  - Full throughput: a new operation every cycle.
- Reset: while resetn=0, out_valid=0, z=0 and status=0, asynchronously; in-flight operations are discarded.
- Combinational logic is pure; the only state is the output register.

Test Plan:
- Default params, rnd=000: a=0x3C00 (1.0), b=0x3C00 -> next cycle out_valid=1, z=0x4000, status=0x00.
- Cancellation: a=0x3C00, b=0xBC00 -> z=0x0000, status=0x01. Same operands with rnd=011 -> z=0x8000, status=0x01.
- Tie rounding: a=0x3C00, b=0x1000 (2^-11):
  - rnd=000 -> z=0x3C00, status=0x20.
  - rnd=010 -> z=0x3C01.
  - rnd=100 -> z=0x3C01.
  - rnd=001 -> z=0x3C00.
- Overflow: a=0x7BFF, b=0x7BFF:
  - rnd=000 -> z=0x7C00, status=0x32.
  - rnd=001 -> z=0x7BFF, status=0x30.
- Specials:
  - a=0x3C00, b=0x0001 (denormal) -> z=0x3C00, status=0x00.
  - a=0x7C00, b=0xFC00 -> z=0x7C00, status=0x06.
- Reset and streaming:
  - Back-to-back operations over 3 cycles -> results appear in order, one per cycle.
  - resetn pulsed low mid-stream -> z=0, status=0, out_valid=0 immediately, without waiting for a clock edge.
